// File: rtl/phase_timer.sv
// Programmable, pausable phase timer: a bank of run-time durations in whole seconds,
// a one-second prescaler, remaining-time readout, pause/abort and a one-cycle done pulse.
module phase_timer #(
   parameter int unsigned CLK_FREQ  = 50000000,
   parameter int unsigned SEC_W     = 8,
   parameter int unsigned SEL_W     = 2,
   parameter int unsigned DEF_LONG  = 25,
   parameter int unsigned DEF_SHORT = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [SEL_W-1:0] sel,
   input  logic             pause,
   input  logic             abort,
   input  logic             cfg_we,
   input  logic [SEL_W-1:0] cfg_addr,
   input  logic [SEC_W-1:0] cfg_data,
   output logic             busy,
   output logic             done,
   output logic             tick,
   output logic [SEC_W-1:0] remaining
);

   localparam int unsigned SLOTS  = 1 << SEL_W;
   localparam logic [31:0] PRE_TC = 32'(CLK_FREQ - 1);

   typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

   state_t           state;
   logic [31:0]      pre;
   logic [SEC_W-1:0] slot [SLOTS];

   // Duration bank; a start on the same edge as a write reads the old value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SLOTS; i++) begin
            slot[i] <= (i == 0) ? SEC_W'(DEF_LONG) : SEC_W'(DEF_SHORT);
         end
      end else if (cfg_we) begin
         slot[cfg_addr] <= cfg_data;
      end
   end

   // Timer FSM; the HOLD->RUN edge already counts, so each HOLD cycle costs one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         pre       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         tick      <= 1'b0;
         remaining <= '0;
      end else begin
         done <= 1'b0;
         tick <= 1'b0;
         if (abort) begin
            state     <= IDLE;
            pre       <= '0;
            remaining <= '0;
            busy      <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     if (slot[sel] != '0) begin
                        state     <= RUN;
                        remaining <= slot[sel];
                        pre       <= '0;
                        busy      <= 1'b1;
                     end else begin
                        done <= 1'b1;
                     end
                  end
               end
               RUN, HOLD: begin
                  if (pause) begin
                     state <= HOLD;
                  end else if (pre == PRE_TC) begin
                     pre       <= '0;
                     tick      <= 1'b1;
                     remaining <= remaining - SEC_W'(1);
                     if (remaining == SEC_W'(1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                     end else begin
                        state <= RUN;
                     end
                  end else begin
                     pre   <= pre + 32'd1;
                     state <= RUN;
                  end
               end
               default: begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_phase_timer.sv
// Bench for phase_timer at CLK_FREQ=10: expected done cycles go into a scoreboard queue,
// a negedge monitor pops one entry per done pulse; level outputs are checked inline.
module tb_phase_timer;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [1:0] sel;
   logic       pause;
   logic       abort;
   logic       cfg_we;
   logic [1:0] cfg_addr;
   logic [7:0] cfg_data;
   logic       busy;
   logic       done;
   logic       tick;
   logic [7:0] remaining;

   typedef struct {
      int    cyc;
      string tag;
   } exp_t;

   exp_t sb[$];
   exp_t got;
   int   cyc    = 0;
   int   checks = 0;
   int   fails  = 0;

   phase_timer #(
      .CLK_FREQ (10),
      .SEC_W    (8),
      .SEL_W    (2),
      .DEF_LONG (25),
      .DEF_SHORT(4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .sel      (sel),
      .pause    (pause),
      .abort    (abort),
      .cfg_we   (cfg_we),
      .cfg_addr (cfg_addr),
      .cfg_data (cfg_data),
      .busy     (busy),
      .done     (done),
      .tick     (tick),
      .remaining(remaining)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every done pulse must match the oldest expected completion.
   always @(negedge clk) begin
      if (!rst && done) begin
         checks++;
         if (sb.size() == 0) begin
            fails++;
            $display("FAIL done_unexpected: got done at cycle %0d, want no done", cyc);
         end else begin
            got = sb.pop_front();
            if (got.cyc != cyc) begin
               fails++;
               $display("FAIL done_%s: got cycle %0d, want cycle %0d", got.tag, cyc, got.cyc);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got time %0t, want finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_to(input int target);
      while (cyc < target) step();
   endtask

   // Pulse start for one edge; e0 is the cycle number of the sampling edge.
   task automatic start_run(input logic [1:0] s, input int dur, input bit expect_done,
                            input string tag, output int e0);
      exp_t e;
      sel   = s;
      start = 1'b1;
      step();
      start = 1'b0;
      e0    = cyc;
      if (expect_done) begin
         e.cyc = e0 + dur;
         e.tag = tag;
         sb.push_back(e);
      end
   endtask

   task automatic write_slot(input logic [1:0] a, input logic [7:0] d);
      cfg_we   = 1'b1;
      cfg_addr = a;
      cfg_data = d;
      step();
      cfg_we   = 1'b0;
   endtask

   initial begin
      int e0;
      int e1;
      int ticks;
      rst = 1'b1; start = 1'b0; sel = '0; pause = 1'b0; abort = 1'b0;
      cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(done), 0);
      chk("reset_tick", int'(tick), 0);
      chk("reset_remaining", int'(remaining), 0);
      rst = 1'b0;
      step();

      // Slot 0: 25 s = 250 cycles, 25 ticks, remaining steps down every 10 cycles.
      start_run(2'd0, 250, 1'b1, "long", e0);
      chk("long_busy_rise", int'(busy), 1);
      chk("long_rem_load", int'(remaining), 25);
      ticks = 0;
      for (int n = 1; n <= 250; n++) begin
         step();
         if (tick) ticks++;
         chk("long_remaining", int'(remaining), 25 - n / 10);
         chk("long_busy", int'(busy), (n < 250) ? 1 : 0);
      end
      chk("long_ticks", ticks, 25);
      step();

      // Slot 1 with pause held for edges 12..26: frozen at 3, done at 55.
      start_run(2'd1, 55, 1'b1, "pause", e0);
      run_to(e0 + 11);
      pause = 1'b1;
      for (int n = 0; n < 15; n++) begin
         step();
         chk("pause_remaining", int'(remaining), 3);
         chk("pause_busy", int'(busy), 1);
      end
      pause = 1'b0;
      run_to(e0 + 55);
      chk("pause_busy_fall", int'(busy), 0);
      chk("pause_rem_zero", int'(remaining), 0);
      step();

      // Write slot 2 mid-run; then start slot 2 while rewriting it (old value 7 wins).
      start_run(2'd1, 40, 1'b1, "cfg_run1", e0);
      run_to(e0 + 4);
      write_slot(2'd2, 8'd7);
      run_to(e0 + 40);
      chk("cfg_run1_busy", int'(busy), 0);
      step();
      cfg_we = 1'b1; cfg_addr = 2'd2; cfg_data = 8'd9;
      start_run(2'd2, 70, 1'b1, "cfg_run2", e1);
      cfg_we = 1'b0;
      chk("cfg_run2_rem_load", int'(remaining), 7);
      run_to(e1 + 70);
      chk("cfg_run2_busy", int'(busy), 0);
      step();

      // Abort at cycle 20 of slot 0; then start+abort together is ignored.
      start_run(2'd0, 0, 1'b0, "abort", e0);
      run_to(e0 + 19);
      abort = 1'b1;
      step();
      abort = 1'b0;
      chk("abort_busy", int'(busy), 0);
      chk("abort_remaining", int'(remaining), 0);
      abort = 1'b1; start = 1'b1; sel = 2'd0;
      step();
      abort = 1'b0; start = 1'b0;
      chk("abort_start_busy", int'(busy), 0);
      repeat (20) step();
      chk("abort_quiet_rem", int'(remaining), 0);

      // Zero-length slot; restart during a run ignored; start accepted while done is high.
      write_slot(2'd3, 8'd0);
      start_run(2'd3, 0, 1'b1, "zero", e0);
      chk("zero_busy", int'(busy), 0);
      step();
      chk("zero_busy_later", int'(busy), 0);
      start_run(2'd1, 40, 1'b1, "retrig", e1);
      run_to(e1 + 12);
      start = 1'b1; sel = 2'd0;
      step();
      start = 1'b0;
      chk("retrig_rem", int'(remaining), 3);
      run_to(e1 + 40);
      chk("retrig_busy", int'(busy), 0);
      start_run(2'd3, 0, 1'b1, "during_done", e0);
      chk("during_done_cycle", e0, e1 + 41);
      step();

      // Asynchronous reset mid-run; slot 2 returns to its default 4 s.
      start_run(2'd0, 0, 1'b0, "rst", e0);
      run_to(e0 + 30);
      #3;
      rst = 1'b1;
      #1;
      chk("rst_busy", int'(busy), 0);
      chk("rst_remaining", int'(remaining), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_tick", int'(tick), 0);
      step();
      step();
      rst = 1'b0;
      step();
      start_run(2'd2, 40, 1'b1, "slot2_default", e0);
      chk("slot2_rem_load", int'(remaining), 4);
      run_to(e0 + 40);
      chk("slot2_busy", int'(busy), 0);
      repeat (3) step();

      chk("scoreboard_empty", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
